// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU.
//   - 4-bit operation codes (alucontrol encoding)
//   - is_iterative(): separates multi-cycle ops (MUL/DIVU/REMU) from single-cycle ops
//   - state_t: controller states IDLE / ITER / DONE
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// alu_seq_comb: purely combinational single-cycle ALU datapath.
// Ports:
//   srca, srcb  in  WIDTH  operands
//   alucontrol  in  4      operation code (alu_seq_pkg encoding)
//   shamt       in  SHW    shift amount (shifts never look at srcb)
//   result      out WIDTH  result; 0 for iterative or unknown codes
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       alucontrol,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (alucontrol)
      OP_ADD:  result = srca + srcb;
      OP_SUB:  result = srca - srcb;
      OP_SLL:  result = srca << shamt;
      OP_SRL:  result = srca >> shamt;
      OP_SRA:  result = WIDTH'($signed(srca) >>> shamt);
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (srca < srcb)};
      OP_XOR:  result = srca ^ srcb;
      OP_OR:   result = srca | srcb;
      OP_AND:  result = srca & srcb;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes on input and output.
// Single-cycle ops finish one cycle after accept; MUL (shift-add) and
// DIVU/REMU (restoring) take WIDTH iterations, i.e. WIDTH+1 cycles.
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   in_valid / in_ready   operand handshake (accept when both high)
//   srca, srcb            operands, latched at accept
//   alucontrol, shamt     operation code and shift amount
//   out_valid / out_ready result handshake (consume when both high)
//   aluout, zero          registered result and aluout==0 flag
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       alucontrol,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluout,
  output logic             zero
);

  state_t           state_reg, state_next;
  logic [SHW-1:0]   count_reg;
  logic [3:0]       op_reg;
  // a_reg: MUL multiplicand (shifts left) / DIV dividend that becomes the quotient
  // b_reg: MUL multiplier (shifts right) / DIV divisor (constant)
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH:0]   rem_reg, rem_next;
  logic [WIDTH-1:0] aluout_reg;
  logic             zero_reg;

  logic [WIDTH-1:0] comb_result;
  logic [WIDTH+1:0] rem_shift;
  logic [WIDTH+1:0] rem_trial;
  logic [WIDTH-1:0] iter_result;
  logic             last_iter;

  alu_seq_comb #(.WIDTH(WIDTH), .SHW(SHW)) u_comb (
    .srca       (srca),
    .srcb       (srcb),
    .alucontrol (alucontrol),
    .shamt      (shamt),
    .result     (comb_result)
  );

  assign last_iter = (count_reg == SHW'(WIDTH - 1));

  // One iteration of the selected iterative algorithm.
  always_comb begin
    a_next   = a_reg;
    b_next   = b_reg;
    acc_next = acc_reg;
    rem_next = rem_reg;
    // Restoring step: bring in the next dividend bit, try subtracting the divisor.
    // A zero divisor always "fits", which yields all-ones quotient and
    // remainder == dividend without any special casing.
    rem_shift = {rem_reg, a_reg[WIDTH-1]};
    rem_trial = rem_shift - {2'b00, b_reg};
    if (op_reg == OP_MUL) begin
      acc_next = b_reg[0] ? (acc_reg + a_reg) : acc_reg;
      a_next   = a_reg << 1;
      b_next   = b_reg >> 1;
    end else if (!rem_trial[WIDTH+1]) begin
      rem_next = rem_trial[WIDTH:0];
      a_next   = {a_reg[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_shift[WIDTH:0];
      a_next   = {a_reg[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    case (op_reg)
      OP_MUL:  iter_result = acc_next;
      OP_DIVU: iter_result = a_next;
      default: iter_result = rem_next[WIDTH-1:0];
    endcase
  end

  // Controller: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Controller: next state and handshake outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = is_iterative(alucontrol) ? ITER : DONE;
      end
      ITER: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg  <= '0;
      op_reg     <= OP_ADD;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      rem_reg    <= '0;
      aluout_reg <= '0;
      zero_reg   <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (is_iterative(alucontrol)) begin
              op_reg    <= alucontrol;
              a_reg     <= srca;
              b_reg     <= srcb;
              acc_reg   <= '0;
              rem_reg   <= '0;
              count_reg <= '0;
            end else begin
              aluout_reg <= comb_result;
              zero_reg   <= (comb_result == '0);
            end
          end
        end
        ITER: begin
          a_reg     <= a_next;
          b_reg     <= b_next;
          acc_reg   <= acc_next;
          rem_reg   <= rem_next;
          // Wraps back to 0 after the last iteration.
          count_reg <= count_reg + SHW'(1);
          if (last_iter) begin
            aluout_reg <= iter_result;
            zero_reg   <= (iter_result == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign aluout = aluout_reg;
  assign zero   = zero_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq (WIDTH=32) against a
// plain-arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic [3:0]  alucontrol = '0;
  logic [4:0]  shamt = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] aluout;
  logic        zero;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .srca       (srca),
    .srcb       (srcb),
    .alucontrol (alucontrol),
    .shamt      (shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .aluout     (aluout),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0101: return a >> sh;
      4'b1101: return $unsigned($signed(a) >>> sh);
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0110: return a | b;
      4'b0111: return a & b;
      4'b1001: return prod[31:0];
      4'b1011: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'b1111: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op);
    return (op == 4'b1001 || op == 4'b1011 || op == 4'b1111) ? 33 : 1;
  endfunction

  // Full transaction: accept, wait for result, check, consume.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
    logic [31:0] exp;
    int lat;
    int cycles;
    logic busy_ok;
    exp = model(op, a, b, sh);
    lat = model_lat(op);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    alucontrol = op; srca = a; srcb = b; shamt = sh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    srca = $urandom; srcb = $urandom; shamt = 5'($urandom);
    cycles = 1;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && cycles < 100) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      cycles++;
    end
    chk("latency", 32'(cycles), 32'(lat));
    chk("in_ready_busy", {31'd0, busy_ok}, 32'd1);
    chk("aluout", aluout, exp);
    chk("zero", {31'd0, zero}, {31'd0, (exp == 32'd0)});
    $display("txn op=%b a=%h b=%h sh=%0d -> aluout=%h zero=%b lat=%0d (model %h)",
             op, a, b, sh, aluout, zero, cycles, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_consumed", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [3:0] ops [14];
    logic ov_seen;
    ops = '{4'b0000, 4'b1000, 4'b0001, 4'b0101, 4'b1101, 4'b0010, 4'b0011,
            4'b0100, 4'b0110, 4'b0111, 4'b1001, 4'b1011, 4'b1111, 4'b1010};

    // Reset values
    #1 reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_aluout", aluout, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
    run_op(4'b1000, 32'd5, 32'd7, 5'd0);
    run_op(4'b1101, 32'h8000_0000, 32'h0000_00FF, 5'd4);
    run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd0);
    run_op(4'b0011, 32'hFFFF_FFFF, 32'd1, 5'd0);
    run_op(4'b1001, 32'h0001_0003, 32'h0001_0005, 5'd0);
    run_op(4'b1011, 32'd100, 32'd7, 5'd0);
    run_op(4'b1111, 32'd100, 32'd7, 5'd0);
    run_op(4'b1011, 32'hDEAD_BEEF, 32'd0, 5'd0);
    run_op(4'b1111, 32'h0000_1234, 32'd0, 5'd0);
    chk("direct_remu_div0", aluout, 32'h0000_1234);

    // Backpressure: result held for 10 cycles, extra in_valid ignored
    alucontrol = 4'b0000; srca = 32'h11; srcb = 32'h22; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    alucontrol = 4'b1000; srca = 32'h1000; srcb = 32'h1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_aluout", aluout, 32'h33);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid_hold", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("bp_out_valid_after", {31'd0, out_valid}, 32'd0);
    $display("txn backpressure hold=10 aluout=%h", aluout);
    run_op(4'b1000, 32'd10, 32'd3, 5'd0);

    // Reset in the middle of a DIVU
    run_op(4'b0110, 32'h0000_1234, 32'h0, 5'd0);
    alucontrol = 4'b1011; srca = 32'd100; srcb = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_div_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_aluout", aluout, 32'd0);
    chk("async_rst_zero", {31'd0, zero}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    ov_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) ov_seen = 1'b1;
    end
    chk("abort_no_out_valid", {31'd0, ov_seen}, 32'd0);
    $display("txn reset-abort divu 100/7 at iteration 10");
    run_op(4'b0000, 32'd2, 32'd3, 5'd0);
    chk("post_reset_add", aluout, 32'd5);

    // Random ops
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [4:0]  sh;
      op = ops[$urandom_range(0, 13)];
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 28));
      sh = 5'($urandom);
      run_op(op, a, b, sh);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
